ctx_reg_file: RTL and testbench
===============================

# ctx_reg_file

Multi-context register file for the packet-processing core: NUM_CTX independent banks of REGS_PER_CTX registers, NUM_RD read ports and one write port, with registered (1-cycle) reads and full write-to-read bypass. Each context has a hardwired zero register (index 0) and a header-pointer register (index REGS_PER_CTX-1) that is loaded automatically on end-of-packet. Storage is cleared after reset by an internal sweep; a one-entry pending buffer absorbs writes that collide with end-of-packet updates. Sits between the instruction decoder and the ALU.

## Interface
- DATA_W, 64, register width
- NUM_CTX, 4, contexts (power of 2)
- REGS_PER_CTX, 32, registers per context (power of 2, ≥4)
- NUM_RD, 2, read ports
- PTR_W, 8, header-pointer width (≤ DATA_W)
- Derived: ADDR_W = clog2(NUM_CTX*REGS_PER_CTX); address = {ctx, reg}; CTX_W = clog2(NUM_CTX)

- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- wen  in  1  write request
- waddr  in  ADDR_W  write address
- din  in  DATA_W  write data
- wr_ready  out  1  write accepted this cycle when high
- end_of_pkt  in  1  load header pointer
- eop_ctx  in  CTX_W  context receiving header pointer
- header_ptr  in  PTR_W  header-pointer value
- raddr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, registered
- ready  out  1  clear sweep complete

## Operation
- States: CLEAR, RUN. rst → CLEAR, counter = 0. CLEAR writes zero to entry counter each cycle; at counter = NUM_CTX*REGS_PER_CTX-1 → RUN. Only rst leaves RUN.
- In CLEAR: ready=0, wr_ready=0, wen and end_of_pkt ignored, rdata = 0.
- Zero register (reg index 0, any ctx): writes discarded, reads return 0 (no bypass).
- EOP write: end_of_pkt in RUN writes zero-extended header_ptr to {eop_ctx, REGS_PER_CTX-1}. Highest priority.
- Normal write: accepted when wen && wr_ready. If no EOP that cycle → commits directly. If EOP same cycle → captured in pending buffer (addr, data). Normal write to a header-pointer register is permitted.
- Pending buffer commits in first subsequent cycle without end_of_pkt. wr_ready = RUN && !pend_valid. wen while wr_ready=0 is dropped; producer must hold.
- EOP and pending to same address: EOP commits first, pending commits later and wins (program order).
- Read value source priority (per port, evaluated at request cycle): zero reg → 0; address == EOP write address this cycle → EOP value; == direct-write address → din; == pending address (pend_valid) → pending data; else storage.

## Timing
- Read latency 1: raddr sampled at edge N, rdata valid after edge N, held until next edge.
- Write visible in storage after its commit edge; bypass makes it visible to a read issued the same cycle.
- Reset values: rdata=0, ready=0, wr_ready=0, pend_valid=0, counter=0.
- Clear takes NUM_CTX*REGS_PER_CTX cycles; ready rises on edge 128 after rst deasserts (defaults).
- rst mid-operation: pending buffer dropped, sweep restarts from 0, contents zeroed.
- Back-to-back EOPs with pending held: pending stays valid, wr_ready stays low until an EOP-free cycle.

## Structure
- Package ctx_reg_file_pkg: state enum (CLEAR, RUN), default parameter constants, functions is_zero_reg(addr) and hdr_reg_addr(ctx).
- Sub-module ctx_reg_bank: flop array, one write port, NUM_RD asynchronous read ports; top level holds FSM, pending buffer, bypass muxes, output registers.

## Test plan
- Reset, then read all 128 addresses → ready rises at cycle 128; every rdata = 0.
- Write 0xDEAD_BEEF to addr 5, read addr 5 same cycle on port 0 → rdata0 = 0xDEAD_BEEF next cycle; write addr 32 (ctx1 reg0) → read returns 0.
- end_of_pkt, eop_ctx=2, header_ptr=0x3C → addr 95 reads 0x3C; addr 31 unchanged.
- wen addr 7 data 0x11 with end_of_pkt same cycle → wr_ready low next cycle, addr 7 read returns 0x11 via pending, committed one cycle later; wen during wr_ready=0 has no effect.
- Three consecutive EOPs with pending valid → pending held, commits on fourth cycle; simultaneous EOP + pending to same address → final value = pending data.
- rst asserted with pending valid mid-run → pending discarded, ready low for 128 cycles, all reads 0.

Source files
------------

// File: rtl/ctx_reg_file_pkg.sv
// rtl/ctx_reg_file_pkg.sv - shared types, defaults and address helpers for ctx_reg_file
package ctx_reg_file_pkg;

  localparam int unsigned DEF_DATA_W       = 64;
  localparam int unsigned DEF_NUM_CTX      = 4;
  localparam int unsigned DEF_REGS_PER_CTX = 32;
  localparam int unsigned DEF_NUM_RD       = 2;
  localparam int unsigned DEF_PTR_W        = 8;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  // Register index 0 of every context is the hardwired zero register.
  function automatic logic is_zero_reg(input int unsigned addr, input int unsigned regs_per_ctx);
    return (addr % regs_per_ctx) == 0;
  endfunction

  function automatic int unsigned hdr_reg_addr(input int unsigned ctx, input int unsigned regs_per_ctx);
    return ctx * regs_per_ctx + regs_per_ctx - 1;
  endfunction

endpackage

// File: rtl/ctx_reg_bank.sv
// rtl/ctx_reg_bank.sv - flop array with one write port and NUM_RD asynchronous read ports
module ctx_reg_bank
  import ctx_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_NUM_CTX * DEF_REGS_PER_CTX,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // No reset on the array: the owner clears it with a sweep after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rdata[i*DATA_W +: DATA_W] = mem_q[raddr[i*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/ctx_reg_file.sv
// rtl/ctx_reg_file.sv - multi-context register file with header-pointer load, pending write buffer and bypass
module ctx_reg_file
  import ctx_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned NUM_CTX      = DEF_NUM_CTX,
  parameter int unsigned REGS_PER_CTX = DEF_REGS_PER_CTX,
  parameter int unsigned NUM_RD       = DEF_NUM_RD,
  parameter int unsigned PTR_W        = DEF_PTR_W,
  localparam int unsigned DEPTH       = NUM_CTX * REGS_PER_CTX,
  localparam int unsigned ADDR_W      = $clog2(DEPTH),
  localparam int unsigned CTX_W       = $clog2(NUM_CTX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        din,
  output logic                     wr_ready,
  input  logic                     end_of_pkt,
  input  logic [CTX_W-1:0]         eop_ctx,
  input  logic [PTR_W-1:0]         header_ptr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     ready
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic [NUM_RD*DATA_W-1:0] rdata_q, rdata_d;

  logic                run;
  logic                eop_act;
  logic [ADDR_W-1:0]   eop_addr;
  logic [DATA_W-1:0]   eop_data;
  logic                wr_acc;
  logic                bank_we;
  logic [ADDR_W-1:0]   bank_waddr;
  logic [DATA_W-1:0]   bank_wdata;
  logic [NUM_RD*DATA_W-1:0] bank_rdata;

  assign run      = (state_q == ST_RUN);
  assign eop_act  = run && end_of_pkt;
  assign eop_addr = ADDR_W'(hdr_reg_addr(32'(eop_ctx), REGS_PER_CTX));
  assign eop_data = DATA_W'(header_ptr);
  // Zero-register writes are swallowed here so they never occupy the pending buffer.
  assign wr_acc   = run && wen && !pend_valid_q && !is_zero_reg(32'(waddr), REGS_PER_CTX);

  assign ready    = run;
  assign wr_ready = run && !pend_valid_q;
  assign rdata    = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (run && pend_valid_q && !end_of_pkt) begin
      pend_valid_d = 1'b0;
    end
    if (wr_acc && end_of_pkt) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = waddr;
      pend_data_d  = din;
    end
  end

  // At most one commit per cycle: pending only drains when wr_ready is already low.
  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = waddr;
    bank_wdata = din;
    if (!run) begin
      bank_we    = 1'b1;
      bank_waddr = cnt_q;
      bank_wdata = '0;
    end else if (eop_act) begin
      bank_we    = 1'b1;
      bank_waddr = eop_addr;
      bank_wdata = eop_data;
    end else if (pend_valid_q) begin
      bank_we    = 1'b1;
      bank_waddr = pend_addr_q;
      bank_wdata = pend_data_q;
    end else if (wr_acc) begin
      bank_we    = 1'b1;
    end
  end

  ctx_reg_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (raddr),
    .rdata (bank_rdata)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_byp
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    assign ra = raddr[i*ADDR_W +: ADDR_W];
    // Later assignments override earlier ones, giving zero > EOP > write > pending > storage.
    always_comb begin
      val = bank_rdata[i*DATA_W +: DATA_W];
      if (pend_valid_q && ra == pend_addr_q) val = pend_data_q;
      if (wr_acc && ra == waddr)             val = din;
      if (eop_act && ra == eop_addr)         val = eop_data;
      if (!run || is_zero_reg(32'(ra), REGS_PER_CTX)) val = '0;
    end
    assign rdata_d[i*DATA_W +: DATA_W] = val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ctx_reg_file.sv
// tb/tb_ctx_reg_file.sv - directed self-checking bench for ctx_reg_file
module tb_ctx_reg_file;

  logic         clk = 1'b0;
  logic         rst;
  logic         wen;
  logic [6:0]   waddr;
  logic [63:0]  din;
  logic         wr_ready;
  logic         end_of_pkt;
  logic [1:0]   eop_ctx;
  logic [7:0]   header_ptr;
  logic [13:0]  raddr;
  logic [127:0] rdata;
  logic         ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctx_reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .din        (din),
    .wr_ready   (wr_ready),
    .end_of_pkt (end_of_pkt),
    .eop_ctx    (eop_ctx),
    .header_ptr (header_ptr),
    .raddr      (raddr),
    .rdata      (rdata),
    .ready      (ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [6:0] a0, input logic [6:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic wr(input logic en, input logic [6:0] a, input logic [63:0] d);
    wen = en; waddr = a; din = d;
  endtask

  task automatic eop(input logic en, input logic [1:0] c, input logic [7:0] p);
    end_of_pkt = en; eop_ctx = c; header_ptr = p;
  endtask

  initial begin
    rst = 1'b1;
    wr(1'b0, 7'd0, 64'd0);
    eop(1'b0, 2'd0, 8'd0);
    rd(7'd0, 7'd0);
    tick();
    tick();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_rdata0", rdata[63:0], 64'd0);
    chk("rst_rdata1", rdata[127:64], 64'd0);

    // Sweep; writes and EOPs during it must be ignored
    rst = 1'b0;
    wr(1'b1, 7'd9, 64'hFF);
    eop(1'b1, 2'd0, 8'h55);
    rd(7'd3, 7'd70);
    for (int k = 1; k <= 128; k++) begin
      tick();
      chk("clr_ready", 64'(ready), (k == 128) ? 64'd1 : 64'd0);
      if (k < 128) begin
        chk("clr_wr_ready", 64'(wr_ready), 64'd0);
        chk("clr_rdata0", rdata[63:0], 64'd0);
      end
    end
    wr(1'b0, 7'd0, 64'd0);
    eop(1'b0, 2'd0, 8'd0);
    chk("run_wr_ready", 64'(wr_ready), 64'd1);

    for (int j = 0; j < 64; j++) begin
      rd(7'(j), 7'(j + 64));
      tick();
      chk("sweep_rd0", rdata[63:0], 64'd0);
      chk("sweep_rd1", rdata[127:64], 64'd0);
    end

    // Write with same-cycle bypass, then from storage
    wr(1'b1, 7'd5, 64'hDEAD_BEEF);
    rd(7'd5, 7'd6);
    tick();
    chk("byp_wr5", rdata[63:0], 64'hDEAD_BEEF);
    chk("byp_rd6", rdata[127:64], 64'd0);
    wr(1'b0, 7'd0, 64'd0);
    tick();
    chk("stor_wr5", rdata[63:0], 64'hDEAD_BEEF);

    // Zero register of ctx1
    wr(1'b1, 7'd32, 64'h1234);
    rd(7'd32, 7'd5);
    tick();
    chk("zero_byp", rdata[63:0], 64'd0);
    chk("zero_other", rdata[127:64], 64'hDEAD_BEEF);
    wr(1'b0, 7'd0, 64'd0);
    tick();
    chk("zero_stor", rdata[63:0], 64'd0);

    // EOP load of ctx2 header pointer
    eop(1'b1, 2'd2, 8'h3C);
    rd(7'd95, 7'd31);
    tick();
    chk("eop_byp95", rdata[63:0], 64'h3C);
    chk("eop_31", rdata[127:64], 64'd0);
    eop(1'b0, 2'd0, 8'd0);
    tick();
    chk("eop_stor95", rdata[63:0], 64'h3C);

    // Write colliding with EOP goes to pending
    wr(1'b1, 7'd7, 64'h11);
    eop(1'b1, 2'd1, 8'h22);
    rd(7'd7, 7'd63);
    tick();
    chk("pend_wr_ready", 64'(wr_ready), 64'd0);
    chk("pend_byp7", rdata[63:0], 64'h11);
    chk("pend_eop63", rdata[127:64], 64'h22);
    wr(1'b1, 7'd8, 64'h99);
    eop(1'b0, 2'd0, 8'd0);
    rd(7'd7, 7'd8);
    tick();
    chk("pend_rd7", rdata[63:0], 64'h11);
    chk("drop_byp8", rdata[127:64], 64'd0);
    chk("pend_done_wr_ready", 64'(wr_ready), 64'd1);
    wr(1'b0, 7'd0, 64'd0);
    tick();
    chk("pend_stor7", rdata[63:0], 64'h11);
    chk("drop_stor8", rdata[127:64], 64'd0);

    // Pending held across three more EOPs
    wr(1'b1, 7'd10, 64'hAA);
    eop(1'b1, 2'd0, 8'd1);
    rd(7'd1, 7'd2);
    tick();
    chk("hold_wr_ready0", 64'(wr_ready), 64'd0);
    wr(1'b0, 7'd0, 64'd0);
    for (int p = 2; p <= 4; p++) begin
      eop(1'b1, 2'd0, 8'(p));
      tick();
      chk("hold_wr_ready", 64'(wr_ready), 64'd0);
    end
    eop(1'b0, 2'd0, 8'd0);
    rd(7'd10, 7'd31);
    tick();
    chk("hold_commit_wr_ready", 64'(wr_ready), 64'd1);
    chk("hold_byp10", rdata[63:0], 64'hAA);
    chk("hold_hdr31", rdata[127:64], 64'd4);
    tick();
    chk("hold_stor10", rdata[63:0], 64'hAA);

    // EOP and pending to the same header register: pending wins
    wr(1'b1, 7'd31, 64'h1234);
    eop(1'b1, 2'd0, 8'h77);
    rd(7'd31, 7'd10);
    tick();
    chk("same_eop31", rdata[63:0], 64'h77);
    wr(1'b0, 7'd0, 64'd0);
    eop(1'b0, 2'd0, 8'd0);
    tick();
    chk("same_pend31", rdata[63:0], 64'h1234);
    tick();
    chk("same_stor31", rdata[63:0], 64'h1234);

    // Reset with pending valid
    wr(1'b1, 7'd12, 64'h5);
    eop(1'b1, 2'd3, 8'hA5);
    rd(7'd12, 7'd127);
    tick();
    chk("rst_pend_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_pend_byp12", rdata[63:0], 64'h5);
    chk("rst_pend_eop127", rdata[127:64], 64'hA5);
    rst = 1'b1;
    wr(1'b0, 7'd0, 64'd0);
    eop(1'b0, 2'd0, 8'd0);
    tick();
    chk("rst2_ready", 64'(ready), 64'd0);
    chk("rst2_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst2_rdata0", rdata[63:0], 64'd0);
    rst = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      tick();
      chk("clr2_ready", 64'(ready), (k == 128) ? 64'd1 : 64'd0);
    end
    chk("clr2_wr_ready", 64'(wr_ready), 64'd1);
    rd(7'd12, 7'd127);
    tick();
    chk("clr2_rd12", rdata[63:0], 64'd0);
    chk("clr2_rd127", rdata[127:64], 64'd0);
    rd(7'd5, 7'd31);
    tick();
    chk("clr2_rd5", rdata[63:0], 64'd0);
    chk("clr2_rd31", rdata[127:64], 64'd0);
    rd(7'd95, 7'd7);
    tick();
    chk("clr2_rd95", rdata[63:0], 64'd0);
    chk("clr2_rd7", rdata[127:64], 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
